dmem_port_arbiter: RTL and testbench
====================================

// Module: dmem_port_arbiter
// PURPOSE
//  Shares the single-port, 1-cycle-read-latency data memory between two requesters:
//  m0 = CPU data path (dmem side of the CPU memory arbiter), m1 = accelerator/frame-buffer
//  DMA. Arbitrates per cycle with round-robin fairness, routes the read return to the
//  owning requester, and keeps a saturating contention counter for performance debug.
// PARAMETERS
//  AWID     10  word-address width of the data memory
//  CNT_W    16  width of the contention counter
// PORTS
//  clk            in   1     system clock, all logic on rising edge
//  resetn         in   1     asynchronous active-low reset
//  m0_req/m1_req  in   1     access request, held until acked
//  mN_we          in   1     1 = write, 0 = read
//  mN_addr        in   AWID  memory address
//  mN_byteen      in   4     byte enables (writes only)
//  mN_wdata       in   32    write data
//  mN_ack         out  1     request accepted this cycle (comb.)
//  mN_rvalid      out  1     read data valid for requester N
//  mN_rdata       out  32    read data, meaningful only while mN_rvalid
//  dmem_addr      out  AWID  memory address
//  dmem_wren      out  1     memory write strobe
//  dmem_byteen    out  4     memory byte enables
//  dmem_wrdata    out  32    memory write data
//  dmem_rddata    in   32    memory read data, valid one cycle after address
//  conflict_cnt_o out  CNT_W cycles with both requests high, saturating
// BEHAVIOUR
//  - Reset: mN_rvalid=0, rd_pend=0, last_gnt=m1 (so m0 wins first tie),
//    conflict_cnt_o=0; dmem_wren=0 while no grant.
//  - Grant (comb.): only one req -> that one; both -> the one NOT in last_gnt;
//    none -> no grant, dmem_wren=0, dmem_addr = m0_addr (don't-care).
//  - mN_ack = grant to N in that cycle; at most one ack per cycle.
//  - Granted request drives dmem_addr/byteen/wrdata; dmem_wren = granted & we.
//  - last_gnt updates on every cycle with a grant, holds otherwise.
//  - Reads: on acked read, rd_pend<=1, rd_owner<=N; next cycle mOwner_rvalid=1 and
//    mOwner_rdata=dmem_rddata. Latency ack->rvalid exactly 1 cycle.
//  - Back-to-back reads (any requester mix) are fully pipelined, one per cycle.
//  - Writes: complete at ack; no rvalid is generated.
//  - Read and write to same address in consecutive cycles: memory order = grant
//    order; a read granted after a write returns the new data.
//  - Non-owner rdata = 0; owner rdata is a passthrough of dmem_rddata.
//  - conflict_cnt_o increments when m0_req & m1_req, sticks at all-ones.
//  - Requesters must hold req/we/addr/data stable until ack (protocol rule). A
//    dropped req before ack is legal; no grant, no side effect.
//  - Reset mid-operation: pending read is discarded; no rvalid after reset.
// TESTING
//  1 m0 read addr 0x010 alone (mem=0xCAFEF00D) -> m0_ack same cycle, m0_rvalid
//    next cycle with 0xCAFEF00D, m1_rvalid stays 0.
//  2 m0 and m1 both request continuously for 6 cycles after reset -> grants
//    m0,m1,m0,m1,m0,m1; conflict_cnt_o = 6.
//  3 m1 write 0x12345678 byteen 4'b0011 to 0x020, then m0 read 0x020 (old
//    0xAAAAAAAA) -> m0_rdata = 0xAAAA5678.
//  4 Alternating reads m0@0x001, m1@0x002, m0@0x003 every cycle -> rvalid each
//    cycle to the correct owner, data matches memory, no bubbles.
//  5 Assert resetn low the cycle after an m1 read ack -> m1_rvalid never asserts,
//    conflict_cnt_o=0, next tie after reset grants m0.
//  6 Force CNT_W=4, hold both reqs 20 cycles -> conflict_cnt_o saturates at 15.

Source files
------------

// File: rtl/dmem_port_arbiter.sv
// Round-robin arbiter sharing a single-port, 1-cycle-latency data memory between
// the CPU data path (m0) and the DMA engine (m1), with a saturating contention counter.
module dmem_port_arbiter #(
  parameter int AWID  = 10,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             resetn,

  input  logic             m0_req,
  input  logic             m0_we,
  input  logic [AWID-1:0]  m0_addr,
  input  logic [3:0]       m0_byteen,
  input  logic [31:0]      m0_wdata,
  output logic             m0_ack,
  output logic             m0_rvalid,
  output logic [31:0]      m0_rdata,

  input  logic             m1_req,
  input  logic             m1_we,
  input  logic [AWID-1:0]  m1_addr,
  input  logic [3:0]       m1_byteen,
  input  logic [31:0]      m1_wdata,
  output logic             m1_ack,
  output logic             m1_rvalid,
  output logic [31:0]      m1_rdata,

  output logic [AWID-1:0]  dmem_addr,
  output logic             dmem_wren,
  output logic [3:0]       dmem_byteen,
  output logic [31:0]      dmem_wrdata,
  input  logic [31:0]      dmem_rddata,

  output logic [CNT_W-1:0] conflict_cnt_o
);

  logic last_gnt;   // 1 = m1 owned the most recent grant
  logic rd_pend;
  logic rd_owner;   // 1 = pending read belongs to m1
  logic gnt0;
  logic gnt1;

  // On a tie the requester that did not win last time is served.
  always_comb begin
    gnt0 = m0_req & (~m1_req | last_gnt);
    gnt1 = m1_req & (~m0_req | ~last_gnt);
  end

  assign m0_ack = gnt0;
  assign m1_ack = gnt1;

  always_comb begin
    dmem_addr   = m0_addr;
    dmem_byteen = m0_byteen;
    dmem_wrdata = m0_wdata;
    dmem_wren   = gnt0 & m0_we;
    if (gnt1) begin
      dmem_addr   = m1_addr;
      dmem_byteen = m1_byteen;
      dmem_wrdata = m1_wdata;
      dmem_wren   = m1_we;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      last_gnt       <= 1'b1;
      rd_pend        <= 1'b0;
      rd_owner       <= 1'b0;
      conflict_cnt_o <= '0;
    end else begin
      if (gnt0)
        last_gnt <= 1'b0;
      else if (gnt1)
        last_gnt <= 1'b1;
      rd_pend  <= (gnt0 & ~m0_we) | (gnt1 & ~m1_we);
      rd_owner <= gnt1;
      if (m0_req && m1_req && !(&conflict_cnt_o))
        conflict_cnt_o <= conflict_cnt_o + CNT_W'(1);
    end
  end

  // Read return is a passthrough gated to the owner; the other port sees zero.
  always_comb begin
    m0_rvalid = rd_pend & ~rd_owner;
    m1_rvalid = rd_pend &  rd_owner;
    m0_rdata  = m0_rvalid ? dmem_rddata : 32'h0;
    m1_rdata  = m1_rvalid ? dmem_rddata : 32'h0;
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: vector table plus read-return scoreboard, with a
// CNT_W=4 instance alongside to exercise counter saturation.
module tb_dmem_port_arbiter;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
  logic [9:0]  m0_addr = '0, m1_addr = '0;
  logic [3:0]  m0_byteen = '0, m1_byteen = '0;
  logic [31:0] m0_wdata = '0, m1_wdata = '0;
  logic        m0_ack, m0_rvalid, m1_ack, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic [9:0]  dmem_addr;
  logic        dmem_wren;
  logic [3:0]  dmem_byteen;
  logic [31:0] dmem_wrdata;
  logic [31:0] dmem_rddata = '0;
  logic [15:0] conflict_cnt;

  logic        s_m0_ack, s_m0_rvalid, s_m1_ack, s_m1_rvalid;
  logic [31:0] s_m0_rdata, s_m1_rdata, s_wrdata;
  logic [9:0]  s_addr;
  logic        s_wren;
  logic [3:0]  s_byteen;
  logic [3:0]  conflict_cnt4;

  always #5 clk = ~clk;

  dmem_port_arbiter #(.AWID(10), .CNT_W(16)) u_dut (
    .clk(clk), .resetn(resetn),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_byteen(m0_byteen),
    .m0_wdata(m0_wdata), .m0_ack(m0_ack), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_byteen(m1_byteen),
    .m1_wdata(m1_wdata), .m1_ack(m1_ack), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .dmem_addr(dmem_addr), .dmem_wren(dmem_wren), .dmem_byteen(dmem_byteen),
    .dmem_wrdata(dmem_wrdata), .dmem_rddata(dmem_rddata),
    .conflict_cnt_o(conflict_cnt)
  );

  dmem_port_arbiter #(.AWID(10), .CNT_W(4)) u_dut4 (
    .clk(clk), .resetn(resetn),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_byteen(m0_byteen),
    .m0_wdata(m0_wdata), .m0_ack(s_m0_ack), .m0_rvalid(s_m0_rvalid), .m0_rdata(s_m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_byteen(m1_byteen),
    .m1_wdata(m1_wdata), .m1_ack(s_m1_ack), .m1_rvalid(s_m1_rvalid), .m1_rdata(s_m1_rdata),
    .dmem_addr(s_addr), .dmem_wren(s_wren), .dmem_byteen(s_byteen),
    .dmem_wrdata(s_wrdata), .dmem_rddata(dmem_rddata),
    .conflict_cnt_o(conflict_cnt4)
  );

  // Single-port synchronous memory, one-cycle read latency.
  logic [31:0] mem [0:1023];
  always @(posedge clk) begin
    if (dmem_wren)
      for (int b = 0; b < 4; b++)
        if (dmem_byteen[b]) mem[dmem_addr][8*b +: 8] <= dmem_wrdata[8*b +: 8];
    dmem_rddata <= mem[dmem_addr];
  end

  typedef struct {
    bit        r0, w0;
    bit [9:0]  a0;
    bit        r1, w1;
    bit [9:0]  a1;
    bit [3:0]  be;
    bit [31:0] wd;
    bit        e0, e1, ewr;
    bit [31:0] ed;
  } vec_t;

  typedef struct {
    bit        owner;
    bit [31:0] data;
  } sb_t;

  sb_t  sbq[$];
  vec_t tbl[20];
  int   n_chk = 0;
  int   n_err = 0;

  function automatic vec_t mk(bit r0, bit w0, bit [9:0] a0, bit r1, bit w1, bit [9:0] a1,
                              bit [3:0] be, bit [31:0] wd, bit e0, bit e1, bit ewr,
                              bit [31:0] ed);
    vec_t v;
    v.r0 = r0; v.w0 = w0; v.a0 = a0; v.r1 = r1; v.w1 = w1; v.a1 = a1;
    v.be = be; v.wd = wd; v.e0 = e0; v.e1 = e1; v.ewr = ewr; v.ed = ed;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One bus cycle: drive at negedge, sample before the next rising edge.
  task automatic apply(input vec_t v);
    sb_t e;
    @(negedge clk);
    m0_req = v.r0; m0_we = v.w0; m0_addr = v.a0; m0_byteen = v.be; m0_wdata = v.wd;
    m1_req = v.r1; m1_we = v.w1; m1_addr = v.a1; m1_byteen = v.be; m1_wdata = v.wd;
    #2;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk("rvalid_owner", {30'b0, m1_rvalid, m0_rvalid}, e.owner ? 32'd2 : 32'd1);
      chk("rdata_owner", e.owner ? m1_rdata : m0_rdata, e.data);
      chk("rdata_nonowner", e.owner ? m0_rdata : m1_rdata, 32'h0);
    end else begin
      chk("rvalid_idle", {30'b0, m1_rvalid, m0_rvalid}, 32'd0);
    end
    chk("ack", {30'b0, m1_ack, m0_ack}, {30'b0, v.e1, v.e0});
    chk("wren", {31'b0, dmem_wren}, {31'b0, v.ewr});
    if (v.e0 && !v.w0) sbq.push_back('{owner: 1'b0, data: v.ed});
    if (v.e1 && !v.w1) sbq.push_back('{owner: 1'b1, data: v.ed});
  endtask

  task automatic idle();
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  task automatic do_reset();
    @(negedge clk);
    m0_req = 0; m1_req = 0;
    resetn = 0;
    sbq.delete();
    repeat (2) @(negedge clk);
    #2;
    chk("rst_cnt", {16'b0, conflict_cnt}, 32'd0);
    chk("rst_rvalid", {30'b0, m1_rvalid, m0_rvalid}, 32'd0);
    chk("rst_wren", {31'b0, dmem_wren}, 32'd0);
    resetn = 1;
  endtask

  initial begin
    tbl[0]  = mk(0,0,0,       1,1,10'h010, 4'hF, 32'hCAFEF00D, 0,1,1, 0);
    tbl[1]  = mk(0,0,0,       1,1,10'h020, 4'hF, 32'hAAAAAAAA, 0,1,1, 0);
    tbl[2]  = mk(0,0,0,       1,1,10'h001, 4'hF, 32'h11111111, 0,1,1, 0);
    tbl[3]  = mk(0,0,0,       1,1,10'h002, 4'hF, 32'h22222222, 0,1,1, 0);
    tbl[4]  = mk(0,0,0,       1,1,10'h003, 4'hF, 32'h33333333, 0,1,1, 0);
    tbl[5]  = mk(1,0,10'h010, 0,0,0,       4'h0, 0,            1,0,0, 32'hCAFEF00D);
    tbl[6]  = mk(0,0,0,       0,0,0,       4'h0, 0,            0,0,0, 0);
    tbl[7]  = mk(0,0,0,       1,1,10'h020, 4'b0011, 32'h12345678, 0,1,1, 0);
    tbl[8]  = mk(1,0,10'h020, 0,0,0,       4'h0, 0,            1,0,0, 32'hAAAA5678);
    tbl[9]  = mk(1,0,10'h001, 0,0,0,       4'h0, 0,            1,0,0, 32'h11111111);
    tbl[10] = mk(0,0,0,       1,0,10'h002, 4'h0, 0,            0,1,0, 32'h22222222);
    tbl[11] = mk(1,0,10'h003, 0,0,0,       4'h0, 0,            1,0,0, 32'h33333333);
    tbl[12] = mk(1,0,10'h001, 1,0,10'h002, 4'h0, 0,            0,1,0, 32'h22222222);
    tbl[13] = mk(1,0,10'h001, 0,0,0,       4'h0, 0,            1,0,0, 32'h11111111);
    tbl[14] = mk(1,1,10'h010, 1,0,10'h010, 4'hF, 32'hDEADBEEF, 0,1,0, 32'hCAFEF00D);
    tbl[15] = mk(1,1,10'h010, 1,0,10'h010, 4'hF, 32'hDEADBEEF, 1,0,1, 0);
    tbl[16] = mk(0,0,0,       1,0,10'h010, 4'h0, 0,            0,1,0, 32'hDEADBEEF);
    tbl[17] = mk(1,0,10'h003, 1,0,10'h001, 4'h0, 0,            1,0,0, 32'h33333333);
    tbl[18] = mk(0,0,0,       0,0,0,       4'h0, 0,            0,0,0, 0);
    tbl[19] = mk(0,0,0,       0,0,0,       4'h0, 0,            0,0,0, 0);

    do_reset();
    for (int i = 0; i < 20; i++) apply(tbl[i]);
    chk("tbl_conflict_cnt", {16'b0, conflict_cnt}, 32'd4);

    // Continuous tie: strict alternation starting with m0.
    do_reset();
    for (int i = 0; i < 6; i++)
      apply(mk(1,0,10'h001, 1,0,10'h002, 0, 0, (i % 2) == 0, (i % 2) == 1, 0,
               (i % 2) == 0 ? 32'h11111111 : 32'h22222222));
    idle();
    chk("tie6_conflict_cnt", {16'b0, conflict_cnt}, 32'd6);

    // Reset lands right after the edge that captured an m1 read.
    do_reset();
    apply(mk(1,0,10'h001, 1,0,10'h002, 0, 0, 1, 0, 0, 32'h11111111));
    apply(mk(0,0,0,       1,0,10'h002, 0, 0, 0, 1, 0, 32'h22222222));
    @(posedge clk);
    #1;
    resetn = 0;
    m1_req = 0;
    sbq.delete();
    idle();
    idle();
    chk("midrst_cnt", {16'b0, conflict_cnt}, 32'd0);
    resetn = 1;
    idle();
    apply(mk(1,0,10'h003, 1,0,10'h001, 0, 0, 1, 0, 0, 32'h33333333));
    idle();
    chk("postrst_cnt", {16'b0, conflict_cnt}, 32'd1);

    // Saturation on the 4-bit counter instance.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      apply(mk(1,0,10'h001, 1,0,10'h002, 0, 0, (i % 2) == 0, (i % 2) == 1, 0,
               (i % 2) == 0 ? 32'h11111111 : 32'h22222222));
      chk("sat_cnt4", {28'b0, conflict_cnt4}, (i < 15) ? i : 15);
    end
    idle();
    chk("sat_cnt4_final", {28'b0, conflict_cnt4}, 32'd15);
    chk("sat_cnt16_final", {16'b0, conflict_cnt}, 32'd20);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
